// File: rtl/eq_coeff_ctrl.sv
// eq_coeff_ctrl: shadow/active biquad coefficient banks with a frame-aligned,
// glitch-free swap that bypasses the EQ for SETTLE_FRAMES frames.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   wr_en/wr_addr/data  shadow coefficient write (idx = section*5 + {b0,b1,b2,a1,a2})
//   commit_req          request shadow->active transfer
//   frame_strobe        one pulse per stereo sample frame
//   enable_req          host EQ enable level
//   coeff_bus           active bank, index k at [k*16 +: 16]
//   eq_enable           EQ datapath enable
//   busy                commit sequence in progress
//   commit_done         one-cycle pulse at end of commit
//   cmd_err             one-cycle pulse on a rejected write/commit
module eq_coeff_ctrl #(
    parameter int N_SECTIONS    = 4,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [4:0]                wr_addr,
    input  logic [15:0]               wr_data,
    input  logic                      commit_req,
    input  logic                      frame_strobe,
    input  logic                      enable_req,
    output logic [N_SECTIONS*80-1:0]  coeff_bus,
    output logic                      eq_enable,
    output logic                      busy,
    output logic                      commit_done,
    output logic                      cmd_err
);

    localparam int NC = N_SECTIONS * 5;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARM    = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    localparam logic [3:0] SF = 4'(SETTLE_FRAMES);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [15:0] shadow [NC];
    logic [15:0] active [NC];

    logic idle;
    logic addr_ok;
    logic shadow_we;
    logic swap;

    assign idle      = (state == S_IDLE);
    assign addr_ok   = ({27'd0, wr_addr} < NC);
    assign shadow_we = idle & wr_en & addr_ok;
    assign swap      = (state == S_ARM) & frame_strobe;
    assign cnt_nxt   = cnt + 4'd1;
    assign busy      = ~idle;

    for (genvar g = 0; g < NC; g++) begin : g_bus
        assign coeff_bus[g*16 +: 16] = active[g];
    end

    // Both banks reset to a unity (pass-through) biquad: b0 = 1.0 in Q2.14.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NC; k++) begin
                shadow[k] <= (k % 5 == 0) ? 16'h4000 : 16'h0000;
                active[k] <= (k % 5 == 0) ? 16'h4000 : 16'h0000;
            end
        end else begin
            if (shadow_we)
                shadow[wr_addr] <= wr_data;
            if (swap) begin
                for (int k = 0; k < NC; k++)
                    active[k] <= shadow[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            eq_enable   <= 1'b0;
            commit_done <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            commit_done <= 1'b0;
            // A rejected write and commit in one cycle merge into one pulse.
            cmd_err <= idle ? (wr_en & ~addr_ok)
                            : (wr_en | commit_req);
            case (state)
                S_IDLE: begin
                    if (frame_strobe)
                        eq_enable <= enable_req;
                    if (commit_req)
                        state <= S_ARM;
                end
                S_ARM: begin
                    if (frame_strobe) begin
                        eq_enable <= 1'b0;
                        cnt       <= 4'd0;
                        state     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    eq_enable <= 1'b0;
                    if (frame_strobe) begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == SF) begin
                            state       <= S_IDLE;
                            eq_enable   <= enable_req;
                            commit_done <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_coeff_ctrl.sv
// tb_eq_coeff_ctrl: directed vector table plus randomized run against a
// behavioural model of the coefficient controller.
module tb_eq_coeff_ctrl;

    localparam int NS = 4;
    localparam int SF = 2;
    localparam int NC = NS * 5;
    localparam int BW = NS * 80;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [15:0]   wr_data;
    logic          commit_req;
    logic          frame_strobe;
    logic          enable_req;
    logic [BW-1:0] coeff_bus;
    logic          eq_enable;
    logic          busy;
    logic          commit_done;
    logic          cmd_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eq_coeff_ctrl #(
        .N_SECTIONS    (NS),
        .SETTLE_FRAMES (SF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .commit_req   (commit_req),
        .frame_strobe (frame_strobe),
        .enable_req   (enable_req),
        .coeff_bus    (coeff_bus),
        .eq_enable    (eq_enable),
        .busy         (busy),
        .commit_done  (commit_done),
        .cmd_err      (cmd_err)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] data;
        logic        cm;
        logic        fs;
        logic        er;
        logic        x_en;
        logic        x_busy;
        logic        x_done;
        logic        x_err;
        logic [15:0] x0;
        logic [15:0] x3;
        logic [15:0] x7;
    } vec_t;

    vec_t tv[20];

    // Behavioural model: a commit is "waiting" for a frame, then
    // "settling" while frames_seen counts up to SF.
    logic [15:0] m_shadow [NC];
    logic [15:0] m_active [NC];
    bit m_waiting;
    bit m_settling;
    int m_frames_seen;
    bit m_en;
    bit m_done;
    bit m_err;

    task automatic chk1(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b",
                     nm, $time, act, exp);
        end
    endtask

    task automatic chk16(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h",
                     nm, $time, act, exp);
        end
    endtask

    task automatic chkb(string nm, logic [BW-1:0] act, logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h",
                     nm, $time, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] unity_bus();
        logic [BW-1:0] b = '0;
        for (int k = 0; k < NC; k += 5)
            b[k*16 +: 16] = 16'h4000;
        return b;
    endfunction

    function automatic logic [BW-1:0] model_bus();
        logic [BW-1:0] b;
        for (int k = 0; k < NC; k++)
            b[k*16 +: 16] = m_active[k];
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_shadow[k] = (k % 5 == 0) ? 16'h4000 : 16'h0000;
            m_active[k] = m_shadow[k];
        end
        m_waiting     = 0;
        m_settling    = 0;
        m_frames_seen = 0;
        m_en          = 0;
        m_done        = 0;
        m_err         = 0;
    endtask

    task automatic model_edge();
        bit was_busy;
        if (rst) begin
            model_reset();
            return;
        end
        was_busy = m_waiting || m_settling;
        m_done = 0;
        m_err  = 0;
        if (!was_busy) begin
            if (wr_en) begin
                if (int'(wr_addr) < NC) m_shadow[wr_addr] = wr_data;
                else m_err = 1;
            end
            if (frame_strobe) m_en = enable_req;
            if (commit_req) m_waiting = 1;
        end else begin
            if (wr_en || commit_req) m_err = 1;
            if (m_waiting && frame_strobe) begin
                m_active      = m_shadow;
                m_en          = 0;
                m_waiting     = 0;
                m_settling    = 1;
                m_frames_seen = 0;
            end else if (m_settling && frame_strobe) begin
                m_frames_seen++;
                if (m_frames_seen == SF) begin
                    m_settling = 0;
                    m_en       = enable_req;
                    m_done     = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chkb("coeff_bus", coeff_bus, model_bus());
        chk1("eq_enable", eq_enable, m_en);
        chk1("busy", busy, m_waiting || m_settling);
        chk1("commit_done", commit_done, m_done);
        chk1("cmd_err", cmd_err, m_err);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_in();
        wr_en        = 0;
        wr_addr      = '0;
        wr_data      = '0;
        commit_req   = 0;
        frame_strobe = 0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    initial begin
        rst        = 1;
        enable_req = 0;
        idle_in();

        //          wr addr  data     cm fs er  en bz dn er  x0       x3       x7
        tv[0]  = '{1, 5'd3,  16'hC123, 0, 0, 1, 0, 0, 0, 0, 16'h4000, 16'h0000, 16'h0000};
        tv[1]  = '{0, 5'd0,  16'h0000, 1, 0, 1, 0, 1, 0, 0, 16'h4000, 16'h0000, 16'h0000};
        tv[2]  = '{0, 5'd0,  16'h0000, 0, 0, 1, 0, 1, 0, 0, 16'h4000, 16'h0000, 16'h0000};
        tv[3]  = '{0, 5'd0,  16'h0000, 0, 1, 1, 0, 1, 0, 0, 16'h4000, 16'hC123, 16'h0000};
        tv[4]  = '{0, 5'd0,  16'h0000, 0, 0, 1, 0, 1, 0, 0, 16'h4000, 16'hC123, 16'h0000};
        tv[5]  = '{0, 5'd0,  16'h0000, 0, 1, 1, 0, 1, 0, 0, 16'h4000, 16'hC123, 16'h0000};
        tv[6]  = '{1, 5'd0,  16'h7777, 0, 0, 1, 0, 1, 0, 1, 16'h4000, 16'hC123, 16'h0000};
        tv[7]  = '{0, 5'd0,  16'h0000, 0, 1, 1, 1, 0, 1, 0, 16'h4000, 16'hC123, 16'h0000};
        tv[8]  = '{1, 5'd20, 16'hBEEF, 0, 0, 1, 1, 0, 0, 1, 16'h4000, 16'hC123, 16'h0000};
        tv[9]  = '{0, 5'd0,  16'h0000, 0, 1, 0, 0, 0, 0, 0, 16'h4000, 16'hC123, 16'h0000};
        tv[10] = '{0, 5'd0,  16'h0000, 0, 0, 1, 0, 0, 0, 0, 16'h4000, 16'hC123, 16'h0000};
        tv[11] = '{0, 5'd0,  16'h0000, 0, 1, 1, 1, 0, 0, 0, 16'h4000, 16'hC123, 16'h0000};
        tv[12] = '{1, 5'd7,  16'h1234, 1, 1, 0, 0, 1, 0, 0, 16'h4000, 16'hC123, 16'h0000};
        tv[13] = '{0, 5'd0,  16'h0000, 0, 1, 0, 0, 1, 0, 0, 16'h4000, 16'hC123, 16'h1234};
        tv[14] = '{0, 5'd0,  16'h0000, 1, 0, 0, 0, 1, 0, 1, 16'h4000, 16'hC123, 16'h1234};
        tv[15] = '{1, 5'd2,  16'h5555, 1, 0, 0, 0, 1, 0, 1, 16'h4000, 16'hC123, 16'h1234};
        tv[16] = '{0, 5'd0,  16'h0000, 0, 0, 0, 0, 1, 0, 0, 16'h4000, 16'hC123, 16'h1234};
        tv[17] = '{0, 5'd0,  16'h0000, 0, 1, 0, 0, 1, 0, 0, 16'h4000, 16'hC123, 16'h1234};
        tv[18] = '{0, 5'd0,  16'h0000, 0, 1, 1, 1, 0, 1, 0, 16'h4000, 16'hC123, 16'h1234};
        tv[19] = '{0, 5'd0,  16'h0000, 0, 0, 1, 1, 0, 0, 0, 16'h4000, 16'hC123, 16'h1234};

        repeat (3) @(posedge clk);
        #1;
        chkb("reset_bus", coeff_bus, unity_bus());
        chk1("reset_en", eq_enable, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", commit_done, 1'b0);
        chk1("reset_err", cmd_err, 1'b0);
        rst = 0;

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            wr_en        = tv[i].wr;
            wr_addr      = tv[i].addr;
            wr_data      = tv[i].data;
            commit_req   = tv[i].cm;
            frame_strobe = tv[i].fs;
            enable_req   = tv[i].er;
            @(posedge clk);
            #1;
            chk1($sformatf("v%0d_en", i), eq_enable, tv[i].x_en);
            chk1($sformatf("v%0d_busy", i), busy, tv[i].x_busy);
            chk1($sformatf("v%0d_done", i), commit_done, tv[i].x_done);
            chk1($sformatf("v%0d_err", i), cmd_err, tv[i].x_err);
            chk16($sformatf("v%0d_c0", i), coeff_bus[0 +: 16], tv[i].x0);
            chk16($sformatf("v%0d_c3", i), coeff_bus[48 +: 16], tv[i].x3);
            chk16($sformatf("v%0d_c7", i), coeff_bus[112 +: 16], tv[i].x7);
        end
        idle_in();

        // Async reset in SETTLE after one strobe, then no stray commit_done
        do_reset();
        wr_en = 1; wr_addr = 5'd1; wr_data = 16'h5555; enable_req = 1;
        tick();
        idle_in(); commit_req = 1;
        tick();
        idle_in(); frame_strobe = 1;
        tick();
        tick();
        idle_in();
        #2;
        rst = 1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            frame_strobe = i[0];
            tick();
        end
        idle_in();

        // Randomized run with occasional resets
        for (int i = 0; i < 3000; i++) begin
            wr_en        = ($urandom_range(0, 3) == 0);
            wr_addr      = 5'($urandom_range(0, 23));
            wr_data      = 16'($urandom);
            commit_req   = ($urandom_range(0, 15) == 0);
            frame_strobe = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) enable_req = ~enable_req;
            rst = ($urandom_range(0, 299) == 0);
            tick();
            rst = 0;
        end
        idle_in();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eq_coeff_ctrl.md
EQ_COEFF_CTRL -- requirements
Module: eq_coeff_ctrl

Interface
REQ-001 Parameter N_SECTIONS, default 4, number of biquad sections whose coefficients are managed.
REQ-002 Parameter SETTLE_FRAMES, default 2, number of frame strobes the EQ is bypassed across a coefficient swap; legal range 1..15.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port wr_en  input  1  shadow coefficient write strobe.
REQ-006 Port wr_addr  input  5  coefficient index = section*5 + {0:b0,1:b1,2:b2,3:a1,4:a2}.
REQ-007 Port wr_data  input  16  signed Q2.14 coefficient value.
REQ-008 Port commit_req  input  1  one-cycle pulse requesting shadow-to-active transfer.
REQ-009 Port frame_strobe  input  1  one-cycle pulse per stereo sample frame (EQ input valid).
REQ-010 Port enable_req  input  1  host-requested EQ enable level.
REQ-011 Port coeff_bus  output  N_SECTIONS*80  active coefficients; index k occupies bits [k*16 +: 16].
REQ-012 Port eq_enable  output  1  enable to the EQ datapath.
REQ-013 Port busy  output  1  high whenever the state is not IDLE.
REQ-014 Port commit_done  output  1  one-cycle pulse when a commit sequence completes.
REQ-015 Port cmd_err  output  1  one-cycle pulse on a rejected write or commit.

Function
REQ-016 The block SHALL hold a shadow bank and an active bank, each N_SECTIONS*5 x 16 bits; coeff_bus SHALL be driven directly from active-bank registers.
REQ-017 States SHALL be IDLE, ARM, SETTLE; busy = (state != IDLE).
REQ-018 In IDLE, wr_en with wr_addr < N_SECTIONS*5 SHALL write wr_data to shadow[wr_addr], visible the next cycle; wr_addr >= N_SECTIONS*5 SHALL write nothing and pulse cmd_err the next cycle.
REQ-019 In ARM or SETTLE, wr_en SHALL write nothing and pulse cmd_err the next cycle; commit_req SHALL be ignored and pulse cmd_err the next cycle.
REQ-020 wr_en and commit_req in the same IDLE cycle: the write SHALL be performed and included in the commit.
REQ-021 wr_en and commit_req both rejected in the same cycle SHALL produce a single one-cycle cmd_err pulse.
REQ-022 IDLE + commit_req at cycle t SHALL enter ARM at t+1; a frame_strobe at cycle t SHALL NOT count toward ARM.
REQ-023 In ARM, a frame_strobe at cycle s SHALL, at s+1: copy the entire shadow bank to the active bank atomically, force eq_enable=0, clear the settle counter, and enter SETTLE.
REQ-024 In SETTLE, each frame_strobe SHALL increment a 4-bit settle counter.
REQ-025 On the strobe that makes the counter equal SETTLE_FRAMES, the block SHALL, at the next cycle: return to IDLE, set eq_enable=enable_req (sampled on that strobe cycle), and pulse commit_done for exactly one cycle.
REQ-026 In IDLE, eq_enable SHALL update to enable_req only on the cycle after a frame_strobe; enable_req changes between strobes SHALL have no effect until the next strobe.
REQ-027 In ARM, eq_enable SHALL keep its IDLE-rule behaviour; in SETTLE it SHALL be held at 0.
REQ-028 Active coefficients SHALL change only on the REQ-023 cycle and never otherwise.
REQ-029 Shadow writes SHALL never alter coeff_bus.

Reset
REQ-030 While rst is high, and on its assertion at any cycle including mid-commit: state=IDLE, counter=0, eq_enable=0, busy=0, commit_done=0, cmd_err=0.
REQ-031 Reset SHALL set both banks to unity: every b0 = 16'h4000, all b1, b2, a1, a2 = 16'h0000.
REQ-032 An aborted commit SHALL leave no pending request after rst deasserts.

Verification
REQ-033 Reset, N_SECTIONS=4 -> coeff_bus has 16'h4000 at indices 0,5,10,15 and 0 elsewhere; eq_enable=0, busy=0.
REQ-034 Write idx 3 = 16'hC123, commit, strobes every 10 cycles, SETTLE_FRAMES=2, enable_req=1 -> coeff_bus idx 3 changes 1 cycle after the first strobe; eq_enable=0 over the next 2 strobes; commit_done and eq_enable=1 one cycle after the 2nd strobe.
REQ-035 wr_addr=20 in IDLE; a write and a commit issued during SETTLE -> one cmd_err pulse each event, shadow and active banks unchanged, single commit_done.
REQ-036 commit_req coincident with frame_strobe -> swap occurs on the following strobe, not the coincident one.
REQ-037 rst asserted in SETTLE after 1 strobe -> all outputs at reset values immediately; no commit_done after rst deasserts.
REQ-038 Toggle enable_req mid-frame in IDLE -> eq_enable follows only 1 cycle after the next frame_strobe.
